// File: rtl/pause_dimmer.sv
// rtl/pause_dimmer.sv - pause arbiter with frame-counted RGB fade to half brightness
// Optional stepped fade: define PAUSE_FADE_EN; otherwise level jumps 8->4 on entering DIM.
module pause_dimmer #(
  parameter int DIM_FRAMES       = 600,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [11:0] rgb_in,
  input  logic        user_pause,
  input  logic        osd_open,
  input  logic        osd_pause_en,
  input  logic        hs_access,
  output logic        pause,
  output logic [11:0] rgb_out,
  output logic        dimmed
);

`ifdef PAUSE_FADE_EN
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FADE = 2'd2, DIM = 2'd3} state_t;
  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES);
`else
  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, DIM = 2'd3} state_t;
`endif

  localparam logic [15:0] DIM_LAST = 16'(DIM_FRAMES);

  state_t      state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  level_q, level_d;
`ifdef PAUSE_FADE_EN
  logic [7:0]  step_cnt_q, step_cnt_d;
`endif
  logic        btn_q, toggle_q, pause_q, vb_q;
  logic [11:0] rgb_q;
  logic        frame_tick;

  // btn_q starts high so a button held through reset does not toggle pause
  assign frame_tick = vblank & ~vb_q;

  // Channel scale: (c * level) >> 3, product never exceeds 120 so 7 bits suffice
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] l);
    logic [6:0] p;
    p = {3'b000, c} * {3'b000, l};
    return 4'(p >> 3);
  endfunction

  // Pause sources: button toggle, OSD request, hiscore access
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      btn_q    <= 1'b1;
      toggle_q <= 1'b0;
      pause_q  <= 1'b0;
      vb_q     <= 1'b1;
    end else begin
      btn_q    <= user_pause;
      if (user_pause & ~btn_q) toggle_q <= ~toggle_q;
      pause_q  <= hs_access | toggle_q | (osd_open & osd_pause_en);
      vb_q     <= vblank;
    end
  end

  // FSM and counter registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      frame_cnt_q <= '0;
      level_q     <= 4'd8;
`ifdef PAUSE_FADE_EN
      step_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      level_q     <= level_d;
`ifdef PAUSE_FADE_EN
      step_cnt_q  <= step_cnt_d;
`endif
    end
  end

  // Next state: unpause always wins over a coincident frame tick
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    level_d     = level_q;
`ifdef PAUSE_FADE_EN
    step_cnt_d  = step_cnt_q;
`endif
    if (state_q != RUN && !pause_q) begin
      state_d     = RUN;
      frame_cnt_d = '0;
      level_d     = 4'd8;
`ifdef PAUSE_FADE_EN
      step_cnt_d  = '0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          frame_cnt_d = '0;
          level_d     = 4'd8;
`ifdef PAUSE_FADE_EN
          step_cnt_d  = '0;
`endif
          if (pause_q) state_d = HOLD;
        end
        HOLD: begin
          if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (frame_cnt_q + 16'd1 == DIM_LAST) begin
`ifdef PAUSE_FADE_EN
              state_d    = FADE;
              step_cnt_d = '0;
`else
              state_d    = DIM;
              level_d    = 4'd4;
`endif
            end
          end
        end
`ifdef PAUSE_FADE_EN
        FADE: begin
          if (frame_tick) begin
            if (step_cnt_q + 8'd1 == STEP_LAST) begin
              step_cnt_d = '0;
              level_d    = level_q - 4'd1;
              if (level_q == 4'd5) state_d = DIM;
            end else begin
              step_cnt_d = step_cnt_q + 8'd1;
            end
          end
        end
`endif
        DIM: begin
          level_d = 4'd4;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Pixel path: one ce_pix of latency, blanked pixels forced to black
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else if (ce_pix) begin
      if (hblank | vblank) rgb_q <= '0;
      else rgb_q <= {scale(rgb_in[11:8], level_q), scale(rgb_in[7:4], level_q),
                     scale(rgb_in[3:0], level_q)};
    end
  end

  assign pause   = pause_q;
  assign rgb_out = rgb_q;
  assign dimmed  = (state_q == DIM);

endmodule

// File: tb/tb_pause_dimmer.sv
// tb/tb_pause_dimmer.sv - self-checking bench for pause_dimmer with a frame-count reference model
module tb_pause_dimmer;
  localparam int DIM = 3;
  localparam int FSF = 2;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ce_pix = 1'b0, hblank = 1'b0, vblank = 1'b0;
  logic [11:0] rgb_in = 12'hF81;
  logic user_pause = 1'b0, osd_open = 1'b0, osd_pause_en = 1'b0, hs_access = 1'b0;
  logic pause, dimmed;
  logic [11:0] rgb_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_btn, m_toggle, m_pause, m_vb, m_active;
  int m_n;
  logic [11:0] m_rgb;

  pause_dimmer #(.DIM_FRAMES(DIM), .FADE_STEP_FRAMES(FSF)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .rgb_in(rgb_in), .user_pause(user_pause), .osd_open(osd_open),
    .osd_pause_en(osd_pause_en), .hs_access(hs_access), .pause(pause),
    .rgb_out(rgb_out), .dimmed(dimmed)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Brightness from number of frame ticks counted while paused
  function automatic int level_of(bit act, int n);
    int l;
    if (!act || n < DIM) return 8;
`ifdef PAUSE_FADE_EN
    l = 8 - (n - DIM) / FSF;
    return (l < 4) ? 4 : l;
`else
    l = 4;
    return l;
`endif
  endfunction

  function automatic logic [11:0] scale_rgb(logic [11:0] c, int l);
    int r, g, b;
    r = (int'(c[11:8]) * l) / 8;
    g = (int'(c[7:4]) * l) / 8;
    b = (int'(c[3:0]) * l) / 8;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic model_reset();
    m_btn = 1; m_toggle = 0; m_pause = 0; m_vb = 1; m_active = 0; m_n = 0; m_rgb = '0;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge
  task automatic model_edge();
    bit press, tick;
    int lvl;
    if (reset) begin
      model_reset();
      return;
    end
    press = user_pause && !m_btn;
    tick = vblank && !m_vb;
    lvl = level_of(m_active, m_n);
    if (ce_pix) m_rgb = (hblank || vblank) ? 12'h000 : scale_rgb(rgb_in, lvl);
    if (!m_active) begin
      if (m_pause) begin m_active = 1; m_n = 0; end
    end else if (!m_pause) begin
      m_active = 0; m_n = 0;
    end else if (tick && m_n < DIM + 4 * FSF + 2) begin
      m_n++;
    end
    m_pause = hs_access || m_toggle || (osd_open && osd_pause_en);
    m_toggle = m_toggle ^ press;
    m_btn = user_pause;
    m_vb = vblank;
  endtask

  task automatic compare_model();
    check("pause", {11'd0, pause}, {11'd0, m_pause});
    check("rgb_out", rgb_out, m_rgb);
    check("dimmed", {11'd0, dimmed}, {11'd0, (m_active && level_of(m_active, m_n) == 4)});
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic vtick();
    vblank = 1'b1; cyc();
    vblank = 1'b0; cyc();
  endtask

  logic [11:0] fade_tbl [8];

  initial begin
    model_reset();
`ifdef PAUSE_FADE_EN
    fade_tbl = '{12'hF81, 12'hD70, 12'hD70, 12'hB60, 12'hB60, 12'h950, 12'h950, 12'h740};
`else
    fade_tbl = '{12'h740, 12'h740, 12'h740, 12'h740, 12'h740, 12'h740, 12'h740, 12'h740};
`endif
    // Reset with the button held
    user_pause = 1'b1;
    #2;
    check("reset_rgb", rgb_out, 12'h000);
    check("reset_pause", {11'd0, pause}, 12'd0);
    check("reset_dimmed", {11'd0, dimmed}, 12'd0);
    repeat (3) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    check("held_btn_pause", {11'd0, pause}, 12'd0);
    user_pause = 1'b0; cyc();
    user_pause = 1'b1; cyc();
    check("press_edge1", {11'd0, pause}, 12'd0);
    cyc();
    check("press_edge2", {11'd0, pause}, 12'd1);
    user_pause = 1'b0; cyc();
    user_pause = 1'b1; cyc(); cyc();
    check("unpress", {11'd0, pause}, 12'd0);
    user_pause = 1'b0; cyc();

    // OSD gating and hiscore access
    osd_open = 1'b1; cyc(); cyc();
    check("osd_no_en", {11'd0, pause}, 12'd0);
    osd_pause_en = 1'b1; cyc();
    check("osd_en", {11'd0, pause}, 12'd1);
    osd_open = 1'b0; osd_pause_en = 1'b0; cyc();
    check("osd_off", {11'd0, pause}, 12'd0);
    hs_access = 1'b1; cyc();
    check("hs_on", {11'd0, pause}, 12'd1);
    hs_access = 1'b0; cyc();
    check("hs_off", {11'd0, pause}, 12'd0);
    cyc();

    // Fade sequence
    ce_pix = 1'b1; rgb_in = 12'hF81;
    cyc();
    check("run_rgb", rgb_out, 12'hF81);
    hs_access = 1'b1; cyc(); cyc();
    vtick(); vtick();
    check("hold_rgb", rgb_out, 12'hF81);
    vtick();
`ifdef PAUSE_FADE_EN
    check("hold_end_rgb", rgb_out, 12'hF81);
    check("hold_end_dim", {11'd0, dimmed}, 12'd0);
`else
    check("hold_end_rgb", rgb_out, 12'h740);
    check("hold_end_dim", {11'd0, dimmed}, 12'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      vtick();
      check($sformatf("fade_%0d", i), rgb_out, fade_tbl[i]);
    end
    check("fade_dimmed", {11'd0, dimmed}, 12'd1);

    // Abort mid-fade, release coincident with a frame tick
    hs_access = 1'b0; cyc(); cyc(); cyc();
    hs_access = 1'b1; cyc(); cyc();
    repeat (5) vtick();
    hs_access = 1'b0; cyc();
    vblank = 1'b1; cyc();
    vblank = 1'b0; cyc();
    check("abort_rgb", rgb_out, 12'hF81);
    check("abort_dim", {11'd0, dimmed}, 12'd0);
    hs_access = 1'b1; cyc(); cyc();
    vtick(); vtick();
    check("repause2_rgb", rgb_out, 12'hF81);
    check("repause2_dim", {11'd0, dimmed}, 12'd0);
    vtick();
`ifdef PAUSE_FADE_EN
    check("repause3_rgb", rgb_out, 12'hF81);
`else
    check("repause3_rgb", rgb_out, 12'h740);
`endif

    // Blanking, then asynchronous reset while dimmed
    hblank = 1'b1; cyc();
    check("hblank_rgb", rgb_out, 12'h000);
    hblank = 1'b0;
    repeat (8) vtick();
    check("dim_rgb", rgb_out, 12'h740);
    check("dim_flag", {11'd0, dimmed}, 12'd1);
    reset = 1'b1;
    #1;
    check("async_rgb", rgb_out, 12'h000);
    check("async_dim", {11'd0, dimmed}, 12'd0);
    check("async_pause", {11'd0, pause}, 12'd0);
    model_reset();
    cyc(); cyc();
    reset = 1'b0; hs_access = 1'b0;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      ce_pix = ($urandom_range(0, 1) == 1);
      hblank = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) vblank = ~vblank;
      rgb_in = 12'($urandom);
      if ($urandom_range(0, 63) == 0) user_pause = ~user_pause;
      if ($urandom_range(0, 127) == 0) osd_open = ~osd_open;
      if ($urandom_range(0, 127) == 0) osd_pause_en = ~osd_pause_en;
      if ($urandom_range(0, 99) == 0) hs_access = ~hs_access;
      if ($urandom_range(0, 1999) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        compare_model();
        cyc();
        reset = 1'b0;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
